aes_enc_pipe: RTL

Parametrised, handshaked AES-128 encryption engine replacing the fixed one-round-per-cycle encryptor in the crypto datapath. Each cycle it applies a configurable number of rounds (1, 2 or 5) using the existing `aes_sbox`, `aes_mixw` and `aes_key_scheduling` cells. It has valid/ready flow control on input and output, an optional key-reuse path, and a compile-time CBC chaining mode. It sits between the DMA block buffer and the output FIFO.

---
 rtl/aes_enc_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_enc_pipe.sv
// aes_enc_pipe: handshaked AES-128 encryptor applying ROUNDS_PER_CYCLE rounds
// (1, 2 or 5) per clock. It has an IDLE/ROUND/HOLD control FSM, a stored-key
// reuse path, and a back-to-back accept in the HOLD cycle.
// Optional build macro AES_CBC_EN adds the in_iv/in_iv_load ports and a
// 128-bit chain register for CBC chaining. Without it the engine is ECB only.
module aes_enc_pipe #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    input  logic         in_key_load,
`ifdef AES_CBC_EN
    input  logic [127:0] in_iv,
    input  logic         in_iv_load,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_rounds
        $error("aes_enc_pipe: ROUNDS_PER_CYCLE must be 1, 2 or 5");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        return C_SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one 32-bit column, first row in the top byte.
    function automatic logic [31:0] aes_mixw(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // One step of the AES-128 key expansion: round key i -> round key i+1.
    function automatic logic [127:0] aes_key_scheduling(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {aes_sbox(k[23:16]) ^ rc, aes_sbox(k[15:8]), aes_sbox(k[7:0]), aes_sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // SubBytes + ShiftRows + (MixColumns unless final round) + AddRoundKey.
    // Byte b of the block sits at bits [127-8b -: 8], and state[r][c] is byte r+4c.
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        int src, dst;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = r + 4*((c + r) % 4);
                dst = r + 4*c;
                t[127-8*dst -: 8] = aes_sbox(st[127-8*src -: 8]);
            end
        end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                t[127-32*c -: 32] = aes_mixw(t[127-32*c -: 32]);
            end
        end
        return t ^ rk;
    endfunction

    state_t        r_state, w_next;
    logic [127:0]  r_data, r_key, r_key_base;
    logic [7:0]    r_rcon;
    logic [3:0]    r_cnt;
    logic          r_busy;
    logic          w_in_ready, w_accept, w_last;
    logic [127:0]  w_key_sel, w_chain;
    logic [127:0]  w_round_state, w_round_key;
    logic [7:0]    w_round_rcon;

    assign w_key_sel = in_key_load ? in_key : r_key_base;
    assign w_accept  = in_valid & w_in_ready;
    assign w_last    = (r_cnt + 4'(ROUNDS_PER_CYCLE - 1)) == 4'd10;

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_data;
    assign busy      = r_busy;

`ifdef AES_CBC_EN
    logic [127:0] r_chain;

    assign w_chain = in_iv_load ? in_iv : r_chain;

    // Chain register captures each ciphertext as the engine enters HOLD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_chain <= '0;
        end else if (r_state == ROUND && w_last) begin
            r_chain <= w_round_state;
        end
    end
`else
    assign w_chain = '0;
`endif

    // Unrolled chain of ROUNDS_PER_CYCLE rounds starting from the registered state.
    always_comb begin
        // NOTE: blocking assignments here let each unrolled round feed the next
        // within the same cycle; registers below use non-blocking only.
        w_round_state = r_data;
        w_round_key   = r_key;
        w_round_rcon  = r_rcon;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            w_round_key   = aes_key_scheduling(w_round_key, w_round_rcon);
            w_round_state = aes_round(w_round_state, w_round_key, (r_cnt + 4'(i)) == 4'd10);
            w_round_rcon  = xtime(w_round_rcon);
        end
    end

    // FSM state register and registered busy flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
        end
    end

    // FSM next-state and input-ready decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can infer a latch.
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = ROUND;
            end
            ROUND: begin
                if (w_last) w_next = HOLD;
            end
            HOLD: begin
                w_in_ready = out_ready;
                if (out_ready) w_next = in_valid ? ROUND : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: load a new block on accept, otherwise advance rounds while in ROUND.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data     <= '0;
            r_key      <= '0;
            r_key_base <= '0;
            r_rcon     <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_key_base <= w_key_sel;
            r_key      <= w_key_sel;
            r_rcon     <= 8'h01;
            r_data     <= in_data ^ w_chain ^ w_key_sel;
            r_cnt      <= 4'd1;
        end else if (r_state == ROUND) begin
            r_data <= w_round_state;
            r_key  <= w_round_key;
            r_rcon <= w_round_rcon;
            r_cnt  <= r_cnt + 4'(ROUNDS_PER_CYCLE);
        end
    end

endmodule
